// File: rtl/divider_result_bcd_pkg.sv
// Shared definitions for the divider result BCD converter: FSM state
// encodings and a helper that sizes the BCD output for a binary width.
package divider_result_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    // Number of decimal digits needed to show the largest unsigned value
    // of the given bit width (2**width - 1). Never returns less than one.
    function automatic int bcd_digits(input int width);
        longint unsigned val;
        int              d;
        val = (64'd1 << width) - 64'd1;
        d   = 0;
        for (int i = 0; i < 20; i++) begin
            if (val != 0) begin
                val = val / 10;
                d++;
            end
        end
        if (d == 0) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/divider_result_bcd_add3.sv
// Double-dabble correction for one BCD nibble: a digit of five or more is
// bumped by three so the following left shift carries into the next digit.
module bcd_add3_digit (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    // Digits never exceed 9 before correction, so the 4-bit sum cannot wrap.
    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/divider_result_bcd.sv
// Sequential binary-to-BCD converter for the divider's quotient and
// remainder. Both values are converted side by side with shift/add-3, one
// bit per clock, and the packed BCD result is handed back with the same
// start_sig/done_sig handshake the divider uses.
module divider_result_bcd
    import divider_result_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = bcd_digits(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_sig,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    output logic                  done_sig,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    generate
        if (DIGITS < bcd_digits(WIDTH)) begin : g_bad_digits
            $error("DIGITS is too small to hold a WIDTH-bit value in BCD");
        end
    endgenerate

    state_e               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WIDTH-1:0]     q_bin_q,   q_bin_d;
    logic [WIDTH-1:0]     r_bin_q,   r_bin_d;
    logic [ACC_W-1:0]     q_acc_q,   q_acc_d;
    logic [ACC_W-1:0]     r_acc_q,   r_acc_d;
    logic [ACC_W-1:0]     q_bcd_q,   q_bcd_d;
    logic [ACC_W-1:0]     r_bcd_q,   r_bcd_d;
    logic                 done_q,    done_d;
    logic                 busy_q,    busy_d;

    logic [ACC_W-1:0]       q_adj;
    logic [ACC_W-1:0]       r_adj;
    logic [ACC_W+WIDTH-1:0] q_shift;
    logic [ACC_W+WIDTH-1:0] r_shift;

    // Per-digit add-3 correction for both accumulators.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3_digit u_q_add3 (
                .d_i (q_acc_q[4*g +: 4]),
                .d_o (q_adj[4*g +: 4])
            );
            bcd_add3_digit u_r_add3 (
                .d_i (r_acc_q[4*g +: 4]),
                .d_o (r_adj[4*g +: 4])
            );
        end
    endgenerate

    // The corrected accumulator and the remaining binary bits shift as one
    // word; the MSB of the binary part enters digit 0.
    assign q_shift = {q_adj, q_bin_q} << 1;
    assign r_shift = {r_adj, r_bin_q} << 1;

    // Next-state and datapath update for the conversion handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_bin_d = q_bin_q;
        r_bin_d = r_bin_q;
        q_acc_d = q_acc_q;
        r_acc_d = r_acc_q;
        q_bcd_d = q_bcd_q;
        r_bcd_d = r_bcd_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start_sig) begin
                    q_bin_d = quotient;
                    r_bin_d = remainder;
                    q_acc_d = '0;
                    r_acc_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                q_acc_d = q_shift[ACC_W+WIDTH-1:WIDTH];
                q_bin_d = q_shift[WIDTH-1:0];
                r_acc_d = r_shift[ACC_W+WIDTH-1:WIDTH];
                r_bin_d = r_shift[WIDTH-1:0];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Publish the result on the same edge that raises done.
                    q_bcd_d = q_shift[ACC_W+WIDTH-1:WIDTH];
                    r_bcd_d = r_shift[ACC_W+WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // A request still held from the previous round must drop
                // before another conversion can be accepted.
                if (!start_sig) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_bin_q <= '0;
            r_bin_q <= '0;
            q_acc_q <= '0;
            r_acc_q <= '0;
            q_bcd_q <= '0;
            r_bcd_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_bin_q <= q_bin_d;
            r_bin_q <= r_bin_d;
            q_acc_q <= q_acc_d;
            r_acc_q <= r_acc_d;
            q_bcd_q <= q_bcd_d;
            r_bcd_q <= r_bcd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign done_sig = done_q;
    assign busy     = busy_q;
    assign q_bcd    = q_bcd_q;
    assign r_bcd    = r_bcd_q;

endmodule
